ahblite_decoder_mux: RTL and testbench

Parametrised AHB-Lite interconnect slice: address-phase decoder plus data-phase response multiplexer for one master and NPORT slaves, with a built-in default slave. Base addresses are programmable per port. Transfers to unmapped or disabled regions get a protocol-correct two-cycle ERROR response, and the errors are counted. The block sits between the bus matrix output (HSEL_M) and the peripheral slaves.

---
 rtl/ahblite_pkg.sv | 24 ++
 rtl/ahblite_decoder_mux_if.sv | 29 ++
 rtl/ahblite_default_slave.sv | 55 +++++
 rtl/ahblite_decoder_mux.sv | 105 ++++++++++
 tb/tb_ahblite_decoder_mux.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahblite_pkg.sv
// Shared types and constants for the AHB-Lite decoder/response-mux slice.
package ahblite_pkg;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Data-phase select codes above the port indices.
  function automatic int dsel_default(input int nport);
    return nport;
  endfunction

  function automatic int dsel_none(input int nport);
    return nport + 1;
  endfunction

endpackage

// File: rtl/ahblite_decoder_mux_if.sv
// Bus bundle between master, decoder/mux slice and the slave ports.
interface ahblite_decoder_mux_if #(
  parameter int NPORT    = 4,
  parameter int ERRCNT_W = 8
) ();
  logic                  HSEL_M;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic [NPORT-1:0]      HSEL_S;
  logic [32*NPORT-1:0]   HRDATA_S;
  logic [NPORT-1:0]      HREADYOUT_S;
  logic [NPORT-1:0]      HRESP_S;
  logic [31:0]           HRDATA;
  logic                  HREADY;
  logic                  HRESP;
  logic [ERRCNT_W-1:0]   ERR_CNT;

  // The slice itself.
  modport slave (
    input  HSEL_M, HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HSEL_S, HRDATA, HREADY, HRESP, ERR_CNT
  );

  // Everything around the slice: master plus attached slaves.
  modport master (
    output HSEL_M, HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HSEL_S, HRDATA, HREADY, HRESP, ERR_CNT
  );
endinterface

// File: rtl/ahblite_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped transfers and a
// saturating count of how many it has answered.
module ahblite_default_slave
  import ahblite_pkg::*;
#(
  parameter int ERRCNT_W = 8
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                sel,
  output logic                readyout,
  output logic                resp,
  output logic [ERRCNT_W-1:0] err_cnt
);

  ds_state_e           state_q, state_d;
  logic                readyout_q, readyout_d;
  logic                resp_q, resp_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (sel) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = sel ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
    // Outputs follow the next state so they come straight from flops.
    readyout_d = (state_d != DS_ERR1);
    resp_d     = (state_d != DS_IDLE);
    err_cnt_d  = err_cnt_q;
    if ((state_d == DS_ERR1) && (state_q != DS_ERR1) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= DS_IDLE;
      readyout_q <= 1'b1;
      resp_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      readyout_q <= readyout_d;
      resp_q     <= resp_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign readyout = readyout_q;
  assign resp     = resp_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: rtl/ahblite_decoder_mux.sv
// AHB-Lite address decoder and data-phase response multiplexer for one
// master and NPORT slaves, with a built-in erroring default slave.
module ahblite_decoder_mux
  import ahblite_pkg::*;
#(
  parameter int                 NPORT     = 4,
  parameter logic [16*NPORT-1:0] PORT_BASE = {16'hA003, 16'hA002, 16'hA001, 16'hA000},
  parameter logic [NPORT-1:0]   PORT_EN   = '1,
  parameter int                 ERRCNT_W  = 8
) (
  input logic              HCLK,
  input logic              HRESET,
  ahblite_decoder_mux_if.slave bus
);

  localparam int DSEL_W = $clog2(NPORT + 2);
  localparam logic [DSEL_W-1:0] DSEL_DEF  = DSEL_W'(dsel_default(NPORT));
  localparam logic [DSEL_W-1:0] DSEL_NONE = DSEL_W'(dsel_none(NPORT));

  logic [NPORT-1:0]  match;
  logic [NPORT-1:0]  hsel;
  logic [NPORT-1:0]  port_dsel;
  logic [31:0]       rdata_term [NPORT];
  logic [DSEL_W-1:0] dsel_q, dsel_d;
  logic [DSEL_W-1:0] port_code;
  logic              default_tgt;
  logic              hready, hresp;
  logic [31:0]       hrdata;
  logic              ds_sel, ds_ready, ds_resp;
  logic              unused_ok;

  for (genvar i = 0; i < NPORT; i++) begin : g_port
    assign match[i]      = bus.HSEL_M & PORT_EN[i] &
                           (bus.HADDR[31:16] == PORT_BASE[16*i +: 16]);
    assign port_dsel[i]  = (dsel_q == DSEL_W'(i));
    assign rdata_term[i] = port_dsel[i] ? bus.HRDATA_S[32*i +: 32] : 32'h0;
  end

  // Lowest index wins, keeping HSEL_S one-hot or zero.
  always_comb begin
    logic hit;
    hit       = 1'b0;
    hsel      = '0;
    port_code = '0;
    for (int i = 0; i < NPORT; i++) begin
      hsel[i] = match[i] & ~hit;
      if (hsel[i]) port_code = DSEL_W'(i);
      hit = hit | match[i];
    end
  end

  assign default_tgt = bus.HSEL_M & ~(|hsel);
  assign bus.HSEL_S  = hsel;

  // Address phase -> data phase boundary.
  always_comb begin
    dsel_d = dsel_q;
    if (hready) begin
      if (!bus.HSEL_M)      dsel_d = DSEL_NONE;
      else if (|hsel)       dsel_d = port_code;
      else                  dsel_d = DSEL_DEF;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) dsel_q <= DSEL_NONE;
    else        dsel_q <= dsel_d;
  end

  assign ds_sel = default_tgt & bus.HTRANS[1] & hready;

  ahblite_default_slave #(.ERRCNT_W(ERRCNT_W)) u_default (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .sel      (ds_sel),
    .readyout (ds_ready),
    .resp     (ds_resp),
    .err_cnt  (bus.ERR_CNT)
  );

  always_comb begin
    hrdata = 32'h0;
    hready = 1'b1;
    hresp  = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      hrdata = hrdata | rdata_term[i];
      if (port_dsel[i]) begin
        hready = bus.HREADYOUT_S[i];
        hresp  = bus.HRESP_S[i];
      end
    end
    if (dsel_q == DSEL_DEF) begin
      hready = ds_ready;
      hresp  = ds_resp;
    end
  end

  assign bus.HRDATA = hrdata;
  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;

  // Sub-region offset and the SEQ/NONSEQ distinction play no part in decode.
  assign unused_ok = ^{bus.HADDR[15:0], bus.HTRANS[0]};

endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// Directed bench for ahblite_decoder_mux: three configurations driven in
// parallel, checked each cycle against a transfer-level model.
module tb_ahblite_decoder_mux;
  import ahblite_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         hsel_m;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [127:0] hrdata_s;
  logic [3:0]   hreadyout_s;
  logic [3:0]   hresp_s;
  logic         chk_en = 1'b0;
  int           n_chk = 0;
  int           n_err = 0;

  ahblite_decoder_mux_if #(.NPORT(4), .ERRCNT_W(8)) bus_a ();
  ahblite_decoder_mux_if #(.NPORT(4), .ERRCNT_W(8)) bus_b ();
  ahblite_decoder_mux_if #(.NPORT(4), .ERRCNT_W(8)) bus_c ();

  assign bus_a.HSEL_M = hsel_m;   assign bus_b.HSEL_M = hsel_m;   assign bus_c.HSEL_M = hsel_m;
  assign bus_a.HADDR  = haddr;    assign bus_b.HADDR  = haddr;    assign bus_c.HADDR  = haddr;
  assign bus_a.HTRANS = htrans;   assign bus_b.HTRANS = htrans;   assign bus_c.HTRANS = htrans;
  assign bus_a.HRDATA_S = hrdata_s;       assign bus_b.HRDATA_S = hrdata_s;       assign bus_c.HRDATA_S = hrdata_s;
  assign bus_a.HREADYOUT_S = hreadyout_s; assign bus_b.HREADYOUT_S = hreadyout_s; assign bus_c.HREADYOUT_S = hreadyout_s;
  assign bus_a.HRESP_S = hresp_s;         assign bus_b.HRESP_S = hresp_s;         assign bus_c.HRESP_S = hresp_s;

  ahblite_decoder_mux #(.NPORT(4), .ERRCNT_W(8)) dut_a (
    .HCLK(clk), .HRESET(rst), .bus(bus_a));
  ahblite_decoder_mux #(.NPORT(4), .PORT_EN(4'b1101), .ERRCNT_W(8)) dut_b (
    .HCLK(clk), .HRESET(rst), .bus(bus_b));
  ahblite_decoder_mux #(.NPORT(4), .PORT_BASE({16'hA003, 16'hA002, 16'hA000, 16'hA000}),
                        .ERRCNT_W(8)) dut_c (
    .HCLK(clk), .HRESET(rst), .bus(bus_c));

  logic [3:0]  a_hsel  [3];
  logic [31:0] a_rdata [3];
  logic        a_ready [3];
  logic        a_resp  [3];
  logic [7:0]  a_cnt   [3];
  assign a_hsel[0] = bus_a.HSEL_S;  assign a_hsel[1] = bus_b.HSEL_S;  assign a_hsel[2] = bus_c.HSEL_S;
  assign a_rdata[0] = bus_a.HRDATA; assign a_rdata[1] = bus_b.HRDATA; assign a_rdata[2] = bus_c.HRDATA;
  assign a_ready[0] = bus_a.HREADY; assign a_ready[1] = bus_b.HREADY; assign a_ready[2] = bus_c.HREADY;
  assign a_resp[0] = bus_a.HRESP;   assign a_resp[1] = bus_b.HRESP;   assign a_resp[2] = bus_c.HRESP;
  assign a_cnt[0] = bus_a.ERR_CNT;  assign a_cnt[1] = bus_b.ERR_CNT;  assign a_cnt[2] = bus_c.ERR_CNT;

  // Address map of each configuration, index = port number.
  logic [15:0] base [3][4] = '{'{16'hA000, 16'hA001, 16'hA002, 16'hA003},
                               '{16'hA000, 16'hA001, 16'hA002, 16'hA003},
                               '{16'hA000, 16'hA000, 16'hA002, 16'hA003}};
  logic        en   [3][4] = '{'{1'b1, 1'b1, 1'b1, 1'b1},
                               '{1'b1, 1'b0, 1'b1, 1'b1},
                               '{1'b1, 1'b1, 1'b1, 1'b1}};

  // Model: who owns the current data phase (-1 nobody, -2 default slave),
  // how many ERROR cycles remain in it, and the error tally.
  int m_tgt [3] = '{-1, -1, -1};
  int m_left[3] = '{0, 0, 0};
  int m_cnt [3] = '{0, 0, 0};

  function automatic int decode(input int d);
    if (!hsel_m) return -1;
    for (int p = 0; p < 4; p++)
      if (en[d][p] && haddr[31:16] == base[d][p]) return p;
    return -2;
  endfunction

  function automatic logic exp_ready(input int d);
    if (m_tgt[d] >= 0)  return hreadyout_s[m_tgt[d]];
    if (m_tgt[d] == -2) return m_left[d] != 2;
    return 1'b1;
  endfunction

  function automatic logic exp_resp(input int d);
    if (m_tgt[d] >= 0)  return hresp_s[m_tgt[d]];
    if (m_tgt[d] == -2) return m_left[d] > 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rdata(input int d);
    if (m_tgt[d] >= 0) return hrdata_s[32*m_tgt[d] +: 32];
    return 32'h0;
  endfunction

  function automatic logic [3:0] exp_hsel(input int d);
    int t;
    t = decode(d);
    return (t >= 0) ? 4'(1 << t) : 4'b0000;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_tgt[d] = -1; m_left[d] = 0; m_cnt[d] = 0;
      end else if (exp_ready(d)) begin
        m_tgt[d] = decode(d);
        if (m_tgt[d] == -2 && htrans[1]) begin
          m_left[d] = 2;
          if (m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
        end else begin
          m_left[d] = 0;
        end
      end else if (m_left[d] == 2) begin
        m_left[d] = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("m%0d_hsel", d),  32'(a_hsel[d]),  32'(exp_hsel(d)));
        chk($sformatf("m%0d_rdata", d), a_rdata[d],      exp_rdata(d));
        chk($sformatf("m%0d_ready", d), 32'(a_ready[d]), 32'(exp_ready(d)));
        chk($sformatf("m%0d_resp", d),  32'(a_resp[d]),  32'(exp_resp(d)));
        chk($sformatf("m%0d_cnt", d),   32'(a_cnt[d]),   32'(m_cnt[d]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [31:0] a, input logic [1:0] t);
    hsel_m = s; haddr = a; htrans = t;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, HTRANS_IDLE);
    hrdata_s    = {32'hDDDD_0003, 32'hCCCC_0002, 32'h1234_5678, 32'hAAAA_0000};
    hreadyout_s = 4'hF;
    hresp_s     = 4'h0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus_a.HREADY), 32'd1);
    chk("rst_resp",  32'(bus_a.HRESP),  32'd0);
    chk("rst_rdata", bus_a.HRDATA,      32'h0);
    chk("rst_cnt",   32'(bus_a.ERR_CNT), 32'd0);

    // Zero-wait read from slave 1.
    drive(1'b1, 32'hA001_0004, HTRANS_NONSEQ);
    #1 chk("t1_hsel", 32'(bus_a.HSEL_S), 32'b0010);
    cyc();
    drive(1'b0, 32'h0, HTRANS_IDLE);
    #1;
    chk("t1_rdata", bus_a.HRDATA, 32'h1234_5678);
    chk("t1_ready", 32'(bus_a.HREADY), 32'd1);
    chk("t1_resp",  32'(bus_a.HRESP),  32'd0);
    cyc();

    // Slave 2 stalls for three cycles while the next address waits.
    drive(1'b1, 32'hA002_0000, HTRANS_NONSEQ);
    hreadyout_s[2] = 1'b0;
    cyc();
    drive(1'b1, 32'hA000_0000, HTRANS_NONSEQ);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_stall_ready", 32'(bus_a.HREADY), 32'd0);
      chk("t2_stall_rdata", bus_a.HRDATA, 32'hCCCC_0002);
      cyc();
    end
    hreadyout_s[2] = 1'b1;
    #1;
    chk("t2_release_ready", 32'(bus_a.HREADY), 32'd1);
    chk("t2_release_rdata", bus_a.HRDATA, 32'hCCCC_0002);
    cyc();
    drive(1'b0, 32'h0, HTRANS_IDLE);
    #1 chk("t2_port0_rdata", bus_a.HRDATA, 32'hAAAA_0000);
    cyc();

    // Unmapped NONSEQ, then IDLE to the same address.
    drive(1'b1, 32'hB000_0000, HTRANS_NONSEQ);
    cyc();
    drive(1'b1, 32'hB000_0000, HTRANS_IDLE);
    #1;
    chk("t3_err1_ready", 32'(bus_a.HREADY), 32'd0);
    chk("t3_err1_resp",  32'(bus_a.HRESP),  32'd1);
    cyc();
    drive(1'b0, 32'h0, HTRANS_IDLE);
    #1;
    chk("t3_err2_ready", 32'(bus_a.HREADY), 32'd1);
    chk("t3_err2_resp",  32'(bus_a.HRESP),  32'd1);
    chk("t3_cnt",        32'(bus_a.ERR_CNT), 32'd1);
    cyc();
    #1;
    chk("t3_idle_ready", 32'(bus_a.HREADY), 32'd1);
    chk("t3_idle_resp",  32'(bus_a.HRESP),  32'd0);
    chk("t3_idle_cnt",   32'(bus_a.ERR_CNT), 32'd1);
    cyc();

    // Disabled port and overlapping bases.
    drive(1'b1, 32'hA001_0000, HTRANS_NONSEQ);
    #1 chk("t4_dis_hsel", 32'(bus_b.HSEL_S), 32'b0000);
    cyc();
    drive(1'b1, 32'hA000_0000, HTRANS_IDLE);
    #1;
    chk("t4_dis_err1", 32'({bus_b.HREADY, bus_b.HRESP}), 32'b01);
    chk("t4_ovl_hsel", 32'(bus_c.HSEL_S), 32'b0001);
    cyc();
    drive(1'b0, 32'h0, HTRANS_IDLE);
    #1 chk("t4_dis_err2", 32'({bus_b.HREADY, bus_b.HRESP}), 32'b11);
    cyc();

    // Slave ERROR response passes through.
    drive(1'b1, 32'hA003_0000, HTRANS_NONSEQ);
    cyc();
    drive(1'b0, 32'h0, HTRANS_IDLE);
    hresp_s[3] = 1'b1;
    #1 chk("t5_slave_resp", 32'(bus_a.HRESP), 32'd1);
    cyc();
    hresp_s[3] = 1'b0;

    // 300 back-to-back unmapped transfers.
    drive(1'b1, 32'hB000_0000, HTRANS_NONSEQ);
    cyc();
    for (int k = 0; k < 300; k++) begin
      #1 chk("t6_err1", 32'({bus_a.HREADY, bus_a.HRESP}), 32'b01);
      cyc();
      if (k == 299) drive(1'b0, 32'h0, HTRANS_IDLE);
      #1 chk("t6_err2", 32'({bus_a.HREADY, bus_a.HRESP}), 32'b11);
      cyc();
    end
    #1 chk("t6_sat_cnt", 32'(bus_a.ERR_CNT), 32'd255);
    cyc();

    // Reset in the middle of ERR1.
    drive(1'b1, 32'hB000_0000, HTRANS_NONSEQ);
    cyc();
    rst = 1'b1;
    drive(1'b0, 32'h0, HTRANS_IDLE);
    #1 chk("t7_err1_ready", 32'(bus_a.HREADY), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("t7_ready", 32'(bus_a.HREADY), 32'd1);
    chk("t7_resp",  32'(bus_a.HRESP),  32'd0);
    chk("t7_cnt",   32'(bus_a.ERR_CNT), 32'd0);
    chk("t7_rdata", bus_a.HRDATA, 32'h0);
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
